// File: rtl/qctrl_pkg.sv
// rtl/qctrl_pkg.sv - shared types and widths for the serial queue controller
package qctrl_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        PUSH    = 2'd2
    } state_e;

endpackage

// File: rtl/bit_collector.sv
// rtl/bit_collector.sv - serial-to-parallel shift register with bit counter
module bit_collector
    import qctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              shift_i,
    input  logic              bit_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              done_o
);

    logic [BYTE_W-1:0] byte_q;
    logic [CNT_W-1:0]  cnt_q;

    // Shift MSB-first with the new bit entering bit 0; the counter wraps naturally after 8 bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            byte_q <= {byte_q[BYTE_W-2:0], bit_i};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign byte_o = byte_q;
    assign done_o = shift_i && (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/serial_queue_ctrl.sv
// rtl/serial_queue_ctrl.sv - serial byte assembler feeding an external queue (QCTRL_AUTO_ENQ_EN: push without enqueue strobe)
module serial_queue_ctrl
    import qctrl_pkg::*;
(
    input  logic              clock_1MHz,
    input  logic              rst,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    output logic              status_out,
    output logic [BYTE_W-1:0] data_out,
    output logic              data_valid_out,
    output logic [1:0]        err_out,
    output logic              q_wr_en_out,
    output logic [BYTE_W-1:0] q_wr_data_out,
    output logic              q_rd_en_out,
    input  logic              q_full_in,
    input  logic              q_empty_in,
    input  logic [BYTE_W-1:0] q_rd_data_in
);

    state_e            state_q, state_d;
    logic              write_q, enq_q, deq_q;
    logic              write_edge, enq_edge, deq_edge;
    logic              shift_en, byte_done;
    logic [BYTE_W-1:0] byte_w;
    logic              ovf_set, unf_set;
    logic              rd_en_q, rd_en_d;
    logic              pend_q, pend_d;
    logic              rd_wait_q;
    logic              valid_q;
    logic [BYTE_W-1:0] data_q;
    logic [1:0]        err_q, err_d;

    assign write_edge = write_in   && !write_q;
    assign enq_edge   = enqueue_in && !enq_q;
    assign deq_edge   = dequeue_in && !deq_q;
    assign shift_en   = write_edge && (state_q == COLLECT);

    bit_collector u_bit_collector (
        .clk_i   (clock_1MHz),
        .rst_ni  (rst),
        .shift_i (shift_en),
        .bit_i   (data_in),
        .byte_o  (byte_w),
        .done_o  (byte_done)
    );

    // Registered copies of the strobes so each held strobe acts only once.
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            write_q <= 1'b0;
            enq_q   <= 1'b0;
            deq_q   <= 1'b0;
        end else begin
            write_q <= write_in;
            enq_q   <= enqueue_in;
            deq_q   <= dequeue_in;
        end
    end

    // Byte FSM state register.
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte FSM next state; a full queue on an enqueue attempt raises overflow and keeps the byte.
    always_comb begin
        state_d = state_q;
        ovf_set = 1'b0;
        case (state_q)
            COLLECT: if (byte_done) state_d = HOLD;
            HOLD: begin
`ifdef QCTRL_AUTO_ENQ_EN
                if (!q_full_in) begin
                    state_d = PUSH;
                end else if (enq_edge) begin
                    ovf_set = 1'b1;
                end
`else
                if (enq_edge) begin
                    if (q_full_in) ovf_set = 1'b1;
                    else           state_d = PUSH;
                end
`endif
            end
            PUSH:    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Dequeue request: a request landing on the PUSH cycle is deferred one cycle so reads never overlap writes.
    always_comb begin
        rd_en_d = 1'b0;
        pend_d  = pend_q;
        unf_set = 1'b0;
        if (pend_q) begin
            pend_d = 1'b0;
            if (q_empty_in) unf_set = 1'b1;
            else            rd_en_d = 1'b1;
        end else if (deq_edge) begin
            if (state_d == PUSH)  pend_d  = 1'b1;
            else if (q_empty_in)  unf_set = 1'b1;
            else                  rd_en_d = 1'b1;
        end
        err_d = err_q | {unf_set, ovf_set};
    end

    // Read pipeline: strobe, one-cycle queue latency, then capture with a valid pulse; sticky error flags.
    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            rd_en_q   <= 1'b0;
            pend_q    <= 1'b0;
            rd_wait_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            err_q     <= 2'b00;
        end else begin
            rd_en_q   <= rd_en_d;
            pend_q    <= pend_d;
            rd_wait_q <= rd_en_q;
            valid_q   <= rd_wait_q;
            if (rd_wait_q) data_q <= q_rd_data_in;
            err_q     <= err_d;
        end
    end

    assign status_out     = (state_q == COLLECT);
    assign q_wr_en_out    = (state_q == PUSH);
    assign q_wr_data_out  = q_wr_en_out ? byte_w : '0;
    assign q_rd_en_out    = rd_en_q;
    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign err_out        = err_q;

endmodule

// File: tb/tb_serial_queue_ctrl.sv
// tb/tb_serial_queue_ctrl.sv - randomized self-checking bench for serial_queue_ctrl
module tb_serial_queue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in, write_in, enqueue_in, dequeue_in;
    logic       status_out, data_valid_out, q_wr_en_out, q_rd_en_out;
    logic [7:0] data_out, q_wr_data_out;
    logic [1:0] err_out;
    logic       q_full_q, q_empty_q;
    logic [7:0] q_rd_data_q;

    always #500 clk = ~clk;

    serial_queue_ctrl dut (
        .clock_1MHz     (clk),
        .rst            (rst),
        .data_in        (data_in),
        .write_in       (write_in),
        .enqueue_in     (enqueue_in),
        .dequeue_in     (dequeue_in),
        .status_out     (status_out),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .err_out        (err_out),
        .q_wr_en_out    (q_wr_en_out),
        .q_wr_data_out  (q_wr_data_out),
        .q_rd_en_out    (q_rd_en_out),
        .q_full_in      (q_full_q),
        .q_empty_in     (q_empty_q),
        .q_rd_data_in   (q_rd_data_q)
    );

    // Queue environment: depth 4, registered flags, read data one clock after the read strobe.
    logic [7:0] env_fifo[$];
    bit         force_full, force_empty;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_fifo.delete();
            q_full_q    <= 1'b0;
            q_empty_q   <= 1'b1;
            q_rd_data_q <= 8'h00;
        end else begin
            if (q_wr_en_out) env_fifo.push_back(q_wr_data_out);
            if (q_rd_en_out && env_fifo.size() > 0) q_rd_data_q <= env_fifo.pop_front();
            q_full_q  <= force_full || (env_fifo.size() >= 4);
            q_empty_q <= force_empty || (env_fifo.size() == 0);
        end
    end

    // Reference model: bits gathered so far, expected queue contents, sticky errors.
    int         m_nbits;
    logic [7:0] m_byte;
    logic [1:0] m_err;
    logic [7:0] m_last;
    logic [7:0] sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit m_full();
        return force_full || (sb.size() >= 4);
    endfunction

    function automatic bit m_empty();
        return force_empty || (sb.size() == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_nbits = 0;
        m_byte  = 8'h00;
        m_err   = 2'b00;
        m_last  = 8'h00;
        sb.delete();
    endtask

    task automatic expect_push(input string tag);
        chk({tag, "_wr_en"}, q_wr_en_out, 1);
        chk({tag, "_wr_data"}, q_wr_data_out, m_byte);
        sb.push_back(m_byte);
        m_nbits = 0;
    endtask

    task automatic send_bit(input bit b, input int hold);
        data_in  = b;
        write_in = 1'b1;
        tick();
        if (m_nbits < 8) begin
            m_byte  = {m_byte[6:0], b};
            m_nbits = m_nbits + 1;
        end
        chk("bit_status", status_out, m_nbits < 8);
        for (int i = 1; i < hold; i++) tick();
        write_in = 1'b0;
`ifdef QCTRL_AUTO_ENQ_EN
        if (m_nbits == 8 && !m_full()) begin
            tick();
            expect_push("auto");
        end
`endif
        tick();
        chk("bit_wr_idle", q_wr_en_out, 0);
        chk("bit_status2", status_out, m_nbits < 8);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1);
    endtask

    task automatic do_enq();
        bit exp_push;
        exp_push   = (m_nbits == 8) && !m_full();
        enqueue_in = 1'b1;
        tick();
        chk("enq_wr_en", q_wr_en_out, exp_push);
        if (exp_push) chk("enq_wr_data", q_wr_data_out, m_byte);
        if (m_nbits == 8 && m_full()) m_err[0] = 1'b1;
        enqueue_in = 1'b0;
        tick();
        if (exp_push) begin
            sb.push_back(m_byte);
            m_nbits = 0;
        end
        chk("enq_wr_once", q_wr_en_out, 0);
        chk("enq_status", status_out, m_nbits < 8);
        chk("enq_err", err_out, m_err);
    endtask

    task automatic do_deq();
        bit exp_rd, hold_wait;
        exp_rd     = !m_empty();
        hold_wait  = (m_nbits == 8);
        dequeue_in = 1'b1;
        tick();
        chk("deq_rd_en", q_rd_en_out, exp_rd);
        dequeue_in = 1'b0;
        tick();
        chk("deq_rd_once", q_rd_en_out, 0);
        chk("deq_valid_early", data_valid_out, 0);
        if (exp_rd) m_last = sb.pop_front();
        else        m_err[1] = 1'b1;
        tick();
        chk("deq_valid", data_valid_out, exp_rd);
        chk("deq_data", data_out, m_last);
`ifdef QCTRL_AUTO_ENQ_EN
        if (hold_wait && exp_rd && !m_full()) expect_push("deq_auto");
`else
        hold_wait = 1'b0;
`endif
        tick();
        chk("deq_valid_pulse", data_valid_out, 0);
        chk("deq_err", err_out, m_err);
    endtask

    task automatic release_full();
        force_full = 1'b0;
        tick();
`ifdef QCTRL_AUTO_ENQ_EN
        if (m_nbits == 8 && !m_full()) begin
            tick();
            expect_push("release");
            tick();
            chk("release_wr_once", q_wr_en_out, 0);
        end
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_status"}, status_out, 1);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_valid"}, data_valid_out, 0);
        chk({tag, "_err"}, err_out, 0);
        chk({tag, "_wr_en"}, q_wr_en_out, 0);
        chk({tag, "_wr_data"}, q_wr_data_out, 0);
        chk({tag, "_rd_en"}, q_rd_en_out, 0);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #100;
        check_reset_outputs(tag);
        model_reset();
        write_in   = 1'b0;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        #100;
        rst = 1'b1;
        tick();
    endtask

`ifndef QCTRL_AUTO_ENQ_EN
    task automatic do_enq_deq();
        bit exp_rd;
        exp_rd     = !force_empty && (sb.size() > 0);
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        tick();
        chk("cfl_rd_en_in_push", q_rd_en_out, 0);
        expect_push("cfl");
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        tick();
        chk("cfl_wr_done", q_wr_en_out, 0);
        chk("cfl_rd_en_after", q_rd_en_out, exp_rd);
        if (exp_rd) m_last = sb.pop_front();
        else        m_err[1] = 1'b1;
        tick();
        chk("cfl_rd_once", q_rd_en_out, 0);
        tick();
        chk("cfl_valid", data_valid_out, exp_rd);
        chk("cfl_data", data_out, m_last);
        tick();
        chk("cfl_err", err_out, m_err);
    endtask
`endif

    initial begin
        rst = 1'b0; data_in = 1'b0; write_in = 1'b0; enqueue_in = 1'b0; dequeue_in = 1'b0;
        force_full = 1'b0; force_empty = 1'b0;
        model_reset();
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Byte 0xB2 into HOLD while the queue reports full: overflow, byte kept, then pushed.
        force_full = 1'b1;
        tick();
        send_byte(8'hB2);
        do_enq();
        chk("ovf_flag", err_out, 2'b01);
        release_full();
`ifndef QCTRL_AUTO_ENQ_EN
        do_enq();
`endif
        chk("b2_in_queue", sb.size(), 1);

        // Second byte, then drain both and underflow on the empty queue.
        send_byte(8'h5A);
        do_enq();
        do_deq();
        chk("first_pop", data_out, 8'hB2);
        do_deq();
        chk("second_pop", data_out, 8'h5A);
        do_deq();
        chk("unf_flag", err_out, 2'b11);

        // Held strobe shifts once; reset after 4 bits discards the partial byte and errors.
        send_bit(1'b1, 5);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 1);
        pulse_reset("mid_byte");
        send_byte(8'hC3);
        do_enq();
        do_deq();
        chk("post_reset_byte", data_out, 8'hC3);

`ifndef QCTRL_AUTO_ENQ_EN
        // Dequeue edge landing on the PUSH cycle is issued the cycle after.
        send_byte(8'h11);
        do_enq();
        send_byte(8'h22);
        do_enq_deq();

        // Reset in the middle of PUSH: no write pulse after release.
        send_byte(8'h3C);
        enqueue_in = 1'b1;
        tick();
        chk("push_before_reset", q_wr_en_out, 1);
        pulse_reset("mid_push");
        chk("no_push_after_reset", q_wr_en_out, 0);
        tick();
        chk("no_push_after_reset2", q_wr_en_out, 0);
`endif

        // Randomized mix against the model.
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55) begin
`ifdef QCTRL_AUTO_ENQ_EN
                if (m_nbits == 7 && m_full()) do_deq();
                else
`endif
                send_bit(1'($urandom_range(0, 1)), (m_nbits >= 7) ? 1 : $urandom_range(1, 3));
            end else if (r < 75) begin
                do_enq();
            end else if (r < 93) begin
                do_deq();
            end else begin
`ifndef QCTRL_AUTO_ENQ_EN
                force_full = ($urandom_range(0, 3) == 0);
`endif
                force_empty = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        force_empty = 1'b0;
        release_full();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
